// File: rtl/cbus_arbiter.sv
// cbus_arbiter: merges the core's instruction-fetch bus and data bus onto one
// shared memory-bus master port with one transaction outstanding at a time.
// Data requests win arbitration. A starvation counter forces a fetch grant
// after STARVE_LIMIT consecutive data grants made while a fetch was waiting.
module cbus_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_valid,
    input  logic [63:0] i_addr,
    output logic        i_data_ok,
    output logic [31:0] i_data,
    input  logic        d_valid,
    input  logic [63:0] d_addr,
    input  logic [2:0]  d_size,
    input  logic [7:0]  d_strobe,
    input  logic [63:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [63:0] d_rdata,
    output logic        c_valid,
    output logic        c_is_write,
    output logic [63:0] c_addr,
    output logic [2:0]  c_size,
    output logic [7:0]  c_strobe,
    output logic [63:0] c_wdata,
    input  logic        c_ready,
    input  logic        c_last,
    input  logic [63:0] c_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic              owner_reg, owner_next;        // 1 = dbus owns the bus
    logic [CNT_W-1:0]  starve_cnt_reg, starve_cnt_next;
    logic              c_valid_reg, c_valid_next;
    logic              c_is_write_reg, c_is_write_next;
    logic [63:0]       c_addr_reg, c_addr_next;
    logic [2:0]        c_size_reg, c_size_next;
    logic [7:0]        c_strobe_reg, c_strobe_next;
    logic [63:0]       c_wdata_reg, c_wdata_next;
    logic              i_data_ok_reg, i_data_ok_next;
    logic [31:0]       i_data_reg, i_data_next;
    logic              d_ok_reg, d_ok_next;
    logic [63:0]       d_rdata_reg, d_rdata_next;

    // Data grant unless a waiting fetch has already been passed over STARVE_LIMIT times.
    logic grant_d;
    assign grant_d = d_valid && !(i_valid && (starve_cnt_reg == STARVE_MAX));

    // State and output registers; async reset abandons any bus transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            owner_reg      <= 1'b0;
            starve_cnt_reg <= '0;
            c_valid_reg    <= 1'b0;
            c_is_write_reg <= 1'b0;
            c_addr_reg     <= '0;
            c_size_reg     <= '0;
            c_strobe_reg   <= '0;
            c_wdata_reg    <= '0;
            i_data_ok_reg  <= 1'b0;
            i_data_reg     <= '0;
            d_ok_reg       <= 1'b0;
            d_rdata_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            starve_cnt_reg <= starve_cnt_next;
            c_valid_reg    <= c_valid_next;
            c_is_write_reg <= c_is_write_next;
            c_addr_reg     <= c_addr_next;
            c_size_reg     <= c_size_next;
            c_strobe_reg   <= c_strobe_next;
            c_wdata_reg    <= c_wdata_next;
            i_data_ok_reg  <= i_data_ok_next;
            i_data_reg     <= i_data_next;
            d_ok_reg       <= d_ok_next;
            d_rdata_reg    <= d_rdata_next;
        end
    end

    // Arbitration, request latching and response generation.
    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        starve_cnt_next = starve_cnt_reg;
        c_valid_next    = c_valid_reg;
        c_is_write_next = c_is_write_reg;
        c_addr_next     = c_addr_reg;
        c_size_next     = c_size_reg;
        c_strobe_next   = c_strobe_reg;
        c_wdata_next    = c_wdata_reg;
        // Response outputs are single-cycle pulses; zero whenever not being set.
        i_data_ok_next  = 1'b0;
        i_data_next     = '0;
        d_ok_next       = 1'b0;
        d_rdata_next    = '0;

        case (state_reg)
            IDLE: begin
                if (grant_d) begin
                    state_next      = REQ;
                    owner_next      = 1'b1;
                    c_valid_next    = 1'b1;
                    c_is_write_next = |d_strobe;
                    c_addr_next     = d_addr;
                    c_size_next     = d_size;
                    c_strobe_next   = d_strobe;
                    c_wdata_next    = d_wdata;
                    if (i_valid) begin
                        if (starve_cnt_reg != STARVE_MAX) begin
                            starve_cnt_next = starve_cnt_reg + 1'b1;
                        end
                    end else begin
                        starve_cnt_next = '0;
                    end
                end else if (i_valid) begin
                    state_next      = REQ;
                    owner_next      = 1'b0;
                    c_valid_next    = 1'b1;
                    c_is_write_next = 1'b0;
                    c_addr_next     = i_addr;
                    c_size_next     = 3'b010;
                    c_strobe_next   = 8'h00;
                    c_wdata_next    = '0;
                    starve_cnt_next = '0;
                end
            end
            REQ: begin
                // Intermediate beats (ready without last) are discarded.
                if (c_ready && c_last) begin
                    state_next   = RESP;
                    c_valid_next = 1'b0;
                    if (owner_reg) begin
                        d_ok_next    = 1'b1;
                        d_rdata_next = c_rdata;
                    end else begin
                        i_data_ok_next = 1'b1;
                        i_data_next    = c_addr_reg[2] ? c_rdata[63:32] : c_rdata[31:0];
                    end
                end
            end
            RESP: begin
                // Requests ignored here so the master sees its pulse before re-arbitration.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign c_valid    = c_valid_reg;
    assign c_is_write = c_is_write_reg;
    assign c_addr     = c_addr_reg;
    assign c_size     = c_size_reg;
    assign c_strobe   = c_strobe_reg;
    assign c_wdata    = c_wdata_reg;
    assign i_data_ok  = i_data_ok_reg;
    assign i_data     = i_data_reg;
    assign d_addr_ok  = d_ok_reg;
    assign d_data_ok  = d_ok_reg;
    assign d_rdata    = d_rdata_reg;

endmodule
